// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - byte FIFO read-port bundle between the FIFO and the UART transmitter
interface fifo_uart_tx_if;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       rd_en;

    // The FIFO drives data and flag; the transmitter drives the read strobe.
    modport master (
        output buf_out,
        output buf_empty,
        input  rd_en
    );

    modport slave (
        input  buf_out,
        input  buf_empty,
        output rd_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining 8-bit UART transmitter (even parity bit when UART_TX_PARITY_EN is defined)
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    fifo_uart_tx_if.slave fifo,
    output logic          tx,
    output logic          busy,
    output logic          tx_done
);

    localparam int unsigned        BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baud_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo.buf_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                baud_d  = '0;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // FIFO data is valid only now, the cycle after the read strobe.
                shift_d  = fifo.buf_out;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo.buf_out;
`endif
                baud_d   = '0;
                tx_d     = 1'b0;
                state_d  = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    // Only point besides IDLE where the empty flag is consulted.
                    baud_d  = '0;
                    state_d = fifo.buf_empty ? S_IDLE : S_FETCH;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign fifo.rd_en = (state_q == S_FETCH);
    assign busy      = (state_q != S_IDLE);
    assign tx_done   = (state_q == S_STOP) && baud_end;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the byte FIFO and drives an 8-bit UART line. It sits directly downstream of the FIFO's read port. When the FIFO is non-empty it issues a single-cycle read, captures the returned byte one cycle later, and serializes it as start bit, 8 data bits LSB first, optional parity, and one stop bit. It repeats until the FIFO reports empty.

## Interface
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 2..65535.

- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- buf_out  input  8  FIFO read data; valid on the cycle after the cycle in which rd_en is high.
- buf_empty  input  1  FIFO empty flag.
- rd_en  output  1  FIFO read strobe; high for exactly one cycle per byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- States: IDLE, FETCH, LATCH, START, DATA, PARITY (macro only), STOP.
- IDLE: if buf_empty==0, go to FETCH; otherwise stay.
- FETCH: one cycle. rd_en=1 (decoded from the registered state; no other state asserts it). Always goes to LATCH.
- LATCH: one cycle. At the edge ending LATCH, buf_out is loaded into an 8-bit shift register. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - 3-bit bit counter counts 0..7.
  - After bit 7, go to PARITY if compiled in, else STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on its final cycle.
  - On exit: if buf_empty==0, go to FETCH; else go to IDLE.
- Baud counter: width sufficient for CLKS_PER_BIT-1. Counts 0..CLKS_PER_BIT-1 and clears on every state change.
- rd_en is never asserted outside FETCH. Underflow protection is therefore only the buf_empty check at IDLE and STOP exit.
- buf_empty is ignored in FETCH, LATCH, START, DATA, PARITY, and before the last STOP cycle.

## Timing
- Reset values: state=IDLE, tx=1, rd_en=0, busy=0, tx_done=0, shift=0x00, counters=0.
- rst asserted mid-frame: tx returns high immediately (asynchronous). The byte in flight is dropped and is not re-read.
- tx is registered and changes on the same edge as the state transition.
- Latency from buf_empty falling while in IDLE:
  - edge 1 enters FETCH;
  - edge 2 enters LATCH;
  - edge 3 drives tx low (start bit).
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back bytes: line stays high for CLKS_PER_BIT+2 cycles between frames (stop bit plus FETCH and LATCH).
- buf_empty rising during a frame has no effect until STOP exit.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state is inserted after DATA.
  - tx = XOR of the 8 latched data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- UART_TX_PARITY_EN undefined: PARITY state and the parity logic are absent; DATA goes directly to STOP; frame is 10 bits.

## Test plan
- Single byte, CLKS_PER_BIT=4, FIFO holds 0xA5 → one rd_en pulse; tx shows 0, then 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1; tx_done pulses at cycle 40 after start-bit onset; busy then returns to 0.
- Two bytes 0x01, 0xFF, CLKS_PER_BIT=4 → two rd_en pulses; inter-frame high time is 6 cycles; second frame data bits are all 1.
- buf_empty held at 1 for 100 cycles → rd_en never asserts; tx=1 and busy=0 throughout.
- rst pulsed during DATA bit 3 of 0x3C → tx=1 and rd_en=0 within the reset cycle; state is IDLE; the next FIFO byte is transmitted intact after rst falls.
- With UART_TX_PARITY_EN, bytes 0x07 then 0x03 → parity bit 1 then 0; each frame is 44 cycles at CLKS_PER_BIT=4.
- CLKS_PER_BIT=2 with a continuously non-empty FIFO holding 8 bytes → exactly 8 rd_en pulses and 8 tx_done pulses; no rd_en while buf_empty=1.
